// File: rtl/io_pad_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// io_pad_ctrl_pkg
// Shared constants and types for the Wishbone pad controller:
//   - byte offsets of the registers inside the 256-byte window
//   - ID register magic value
//   - register reset values (truncated to N_PADS at the point of use)
//   - Wishbone slave FSM state type
//   - byte-enable expansion helper
// ---------------------------------------------------------------------------
package io_pad_ctrl_pkg;

  localparam logic [7:0] OFF_MODE     = 8'h00;
  localparam logic [7:0] OFF_OUT      = 8'h04;
  localparam logic [7:0] OFF_OEB      = 8'h08;
  localparam logic [7:0] OFF_IN       = 8'h0C;
  localparam logic [7:0] OFF_RISE_EN  = 8'h10;
  localparam logic [7:0] OFF_FALL_EN  = 8'h14;
  localparam logic [7:0] OFF_IRQ_STAT = 8'h18;
  localparam logic [7:0] OFF_ID       = 8'h1C;

  localparam logic [15:0] ID_MAGIC = 16'h10C0;

  localparam logic [31:0] MODE_RST     = 32'h0000_0000;
  localparam logic [31:0] OUT_RST      = 32'h0000_0000;
  localparam logic [31:0] OEB_RST      = 32'hFFFF_FFFF;
  localparam logic [31:0] RISE_EN_RST  = 32'h0000_0000;
  localparam logic [31:0] FALL_EN_RST  = 32'h0000_0000;
  localparam logic [31:0] IRQ_STAT_RST = 32'h0000_0000;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_ACK  = 1'b1
  } wb_state_e;

  // Expand the four Wishbone byte enables into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/io_pad_ctrl_if.sv
// ---------------------------------------------------------------------------
// io_pad_ctrl_if
// Wishbone classic slave bundle for the pad controller.
//   wbs_cyc_i/stb_i/we_i  : cycle, strobe, write enable (master -> slave)
//   wbs_sel_i[3:0]        : byte enables
//   wbs_adr_i[31:0]       : byte address
//   wbs_dat_i[31:0]       : write data
//   wbs_ack_o             : one-cycle transfer acknowledge (slave -> master)
//   wbs_dat_o[31:0]       : read data, valid while ack is high, else 0
// ---------------------------------------------------------------------------
interface io_pad_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/io_edge_sync.sv
// ---------------------------------------------------------------------------
// io_edge_sync
// One pad input: SYNC_STAGES-deep synchroniser, a previous-value flop on the
// last stage, and single-cycle rise/fall strobes derived from them.
//   clk, rst : clock, synchronous active-high reset
//   pad_i    : asynchronous pad input
//   sync_o   : synchronised pad value (last stage)
//   rise_o   : last stage went 0 -> 1
//   fall_o   : last stage went 1 -> 0
// ---------------------------------------------------------------------------
module io_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // so the chain shifts one stage per clock instead of collapsing.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/io_pad_ctrl.sv
// ---------------------------------------------------------------------------
// io_pad_ctrl
// Wishbone-programmable controller for N_PADS GPIO pads. Each pad is either
// passed through from the core or driven from the OUT/OEB registers. Pad
// inputs are synchronised and rising/falling edges latch into IRQ_STAT (W1C).
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   wb                 : Wishbone classic slave (io_pad_ctrl_if.slave)
//   pad_in             : from pads
//   pad_out, pad_oeb   : to pads (oeb 1 = output disabled)
//   core_out, core_oeb : drive requested by the core in passthrough mode
//   core_in            : pad_in forwarded to the core, unregistered
//   irq                : OR of all IRQ_STAT bits
// ---------------------------------------------------------------------------
module io_pad_ctrl
  import io_pad_ctrl_pkg::*;
#(
  parameter int          N_PADS      = 16,
  parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  io_pad_ctrl_if.slave      wb,
  input  logic [N_PADS-1:0] pad_in,
  output logic [N_PADS-1:0] pad_out,
  output logic [N_PADS-1:0] pad_oeb,
  input  logic [N_PADS-1:0] core_out,
  input  logic [N_PADS-1:0] core_oeb,
  output logic [N_PADS-1:0] core_in,
  output logic              irq
);

  typedef logic [N_PADS-1:0] pad_vec_t;

  wb_state_e   state_q, state_d;
  logic [31:0] dat_q, dat_d;

  pad_vec_t mode_q, mode_d;
  pad_vec_t out_q, out_d;
  pad_vec_t oeb_q, oeb_d;
  pad_vec_t rise_en_q, rise_en_d;
  pad_vec_t fall_en_q, fall_en_d;
  pad_vec_t irq_stat_q, irq_stat_d;

  pad_vec_t    in_sync, rise, fall, irq_set, w1c, wr_mask, wr_data;
  logic [31:0] sel_bytes, rdata;
  logic [7:0]  reg_off;
  logic        hit, access, wr_en;
  logic        unused_bits;

  function automatic pad_vec_t merge(input pad_vec_t old, input pad_vec_t d,
                                     input pad_vec_t m);
    return (old & ~m) | (d & m);
  endfunction

  // -------------------------------------------------------------------------
  // Address decode. Only one access per ACK pulse: while in WB_ACK a still
  // asserted strobe is ignored, which forces an idle cycle between acks.
  // -------------------------------------------------------------------------
  assign hit       = wb.wbs_cyc_i & wb.wbs_stb_i &
                     (wb.wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign access    = hit & (state_q == WB_IDLE);
  assign wr_en     = access & wb.wbs_we_i;
  assign reg_off   = {wb.wbs_adr_i[7:2], 2'b00};
  assign sel_bytes = byte_mask(wb.wbs_sel_i);
  assign wr_mask   = sel_bytes[N_PADS-1:0];
  assign wr_data   = wb.wbs_dat_i[N_PADS-1:0];

  // Byte lanes and bits beyond N_PADS carry no state.
  assign unused_bits = ^{wb.wbs_adr_i[1:0], wb.wbs_dat_i, sel_bytes};

  // -------------------------------------------------------------------------
  // Per-pad synchronisers and edge detectors.
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < N_PADS; i++) begin : g_pad
    io_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (wb_clk_i),
      .rst    (wb_rst_i),
      .pad_i  (pad_in[i]),
      .sync_o (in_sync[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

  assign irq_set = (rise & rise_en_q) | (fall & fall_en_q);

  // -------------------------------------------------------------------------
  // Register file write path. IN, ID and unmapped offsets fall into default.
  // -------------------------------------------------------------------------
  always_comb begin
    mode_d    = mode_q;
    out_d     = out_q;
    oeb_d     = oeb_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    if (wr_en) begin
      case (reg_off)
        OFF_MODE:     mode_d    = merge(mode_q, wr_data, wr_mask);
        OFF_OUT:      out_d     = merge(out_q, wr_data, wr_mask);
        OFF_OEB:      oeb_d     = merge(oeb_q, wr_data, wr_mask);
        OFF_RISE_EN:  rise_en_d = merge(rise_en_q, wr_data, wr_mask);
        OFF_FALL_EN:  fall_en_d = merge(fall_en_q, wr_data, wr_mask);
        OFF_IRQ_STAT: w1c       = wr_data & wr_mask;
        default: ;
      endcase
    end
    // Clear first, then set, so a new edge in the same cycle survives.
    irq_stat_d = (irq_stat_q & ~w1c) | irq_set;
  end

  // -------------------------------------------------------------------------
  // Read mux, sampled into dat_q on the ack edge.
  // -------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    case (reg_off)
      OFF_MODE:     rdata[N_PADS-1:0] = mode_q;
      OFF_OUT:      rdata[N_PADS-1:0] = out_q;
      OFF_OEB:      rdata[N_PADS-1:0] = oeb_q;
      OFF_IN:       rdata[N_PADS-1:0] = in_sync;
      OFF_RISE_EN:  rdata[N_PADS-1:0] = rise_en_q;
      OFF_FALL_EN:  rdata[N_PADS-1:0] = fall_en_q;
      OFF_IRQ_STAT: rdata[N_PADS-1:0] = irq_stat_q;
      OFF_ID:       rdata             = {ID_MAGIC, 8'd0, 8'(N_PADS)};
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Wishbone FSM: IDLE -> ACK on a selected strobe, ACK -> IDLE always.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves
    // it unassigned and no latch is inferred.
    state_d = state_q;
    dat_d   = '0;
    case (state_q)
      WB_IDLE: begin
        if (hit) begin
          state_d = WB_ACK;
          if (!wb.wbs_we_i) dat_d = rdata;
        end
      end
      WB_ACK:  state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= WB_IDLE;
      dat_q      <= '0;
      mode_q     <= MODE_RST[N_PADS-1:0];
      out_q      <= OUT_RST[N_PADS-1:0];
      oeb_q      <= OEB_RST[N_PADS-1:0];
      rise_en_q  <= RISE_EN_RST[N_PADS-1:0];
      fall_en_q  <= FALL_EN_RST[N_PADS-1:0];
      irq_stat_q <= IRQ_STAT_RST[N_PADS-1:0];
    end else begin
      state_q    <= state_d;
      dat_q      <= dat_d;
      mode_q     <= mode_d;
      out_q      <= out_d;
      oeb_q      <= oeb_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      irq_stat_q <= irq_stat_d;
    end
  end

  assign wb.wbs_ack_o = (state_q == WB_ACK);
  assign wb.wbs_dat_o = dat_q;

  // -------------------------------------------------------------------------
  // Pad mux and core-side outputs.
  // -------------------------------------------------------------------------
  assign pad_out = (mode_q & out_q) | (~mode_q & core_out);
  assign pad_oeb = (mode_q & oeb_q) | (~mode_q & core_oeb);
  assign core_in = pad_in;
  assign irq     = |irq_stat_q;

endmodule

// File: tb/tb_io_pad_ctrl.sv
// ---------------------------------------------------------------------------
// tb_io_pad_ctrl
// Self-checking bench for io_pad_ctrl (N_PADS=16, SYNC_STAGES=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A behavioural model tracks the register contents, a pad_in history queue
// (synchronised value = pad_in seen SYNC_STAGES edges ago) and IRQ_STAT.
// ---------------------------------------------------------------------------
module tb_io_pad_ctrl;
  import io_pad_ctrl_pkg::*;

  localparam int          N     = 16;
  localparam int          S     = 2;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [31:0] PMASK = 32'h0000_FFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] pad_in, pad_out, pad_oeb, core_out, core_oeb, core_in;
  logic         irq;

  always #5 clk = ~clk;

  io_pad_ctrl_if wb ();

  io_pad_ctrl #(.N_PADS(N), .BASE_ADR(BASE), .SYNC_STAGES(S)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (wb),
    .pad_in   (pad_in),
    .pad_out  (pad_out),
    .pad_oeb  (pad_oeb),
    .core_out (core_out),
    .core_oeb (core_oeb),
    .core_in  (core_in),
    .irq      (irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mode, m_out, m_oeb, m_rise, m_fall, m_stat, m_exp_rd;
  logic        m_ack;
  logic [31:0] hist[$];  // hist[0] = pad_in at most recent edge

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] sel);
    logic [31:0] m;
    m = PMASK & {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] off);
    case (off)
      8'h00:   return m_mode;
      8'h04:   return m_out;
      8'h08:   return m_oeb;
      8'h0C:   return hist[S-1];
      8'h10:   return m_rise;
      8'h14:   return m_fall;
      8'h18:   return m_stat;
      8'h1C:   return 32'h10C0_0010;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_out = 0; m_oeb = PMASK; m_rise = 0; m_fall = 0; m_stat = 0;
    m_ack = 1'b0; m_exp_rd = 0;
    hist.delete();
    for (int i = 0; i <= S; i++) hist.push_back(32'h0);
  endtask

  // Advance one clock: update the model at the rising edge, return at the
  // following falling edge where outputs are sampled and inputs are driven.
  task automatic step();
    logic [31:0] s, p, setv, w1c, d;
    logic [7:0]  off;
    logic        acc;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      s    = hist[S-1];
      p    = hist[S];
      setv = ((s & ~p) & m_rise) | ((~s & p) & m_fall);
      acc  = wb.wbs_cyc_i && wb.wbs_stb_i && (wb.wbs_adr_i[31:8] == BASE[31:8]) && !m_ack;
      off  = {wb.wbs_adr_i[7:2], 2'b00};
      d    = wb.wbs_dat_i;
      w1c  = 0;
      if (acc) begin
        m_exp_rd = wb.wbs_we_i ? 32'h0 : m_read(off);
        if (wb.wbs_we_i) begin
          case (off)
            8'h00: m_mode = m_merge(m_mode, d, wb.wbs_sel_i);
            8'h04: m_out  = m_merge(m_out, d, wb.wbs_sel_i);
            8'h08: m_oeb  = m_merge(m_oeb, d, wb.wbs_sel_i);
            8'h10: m_rise = m_merge(m_rise, d, wb.wbs_sel_i);
            8'h14: m_fall = m_merge(m_fall, d, wb.wbs_sel_i);
            8'h18: w1c    = m_merge(32'h0, d, wb.wbs_sel_i);
            default: ;
          endcase
        end
      end
      m_stat = (m_stat & ~w1c) | setv;
      m_ack  = acc;
      hist.push_front(32'(pad_in));
      void'(hist.pop_back());
    end
    @(negedge clk);
  endtask

  // One Wishbone transfer; lat = cycles to ack (0 = no ack within 3 cycles).
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd, output int lat);
    int n;
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
    wb.wbs_adr_i = adr;  wb.wbs_dat_i = dat;  wb.wbs_sel_i = sel;
    lat = 0; rd = 0; n = 0;
    while (lat == 0 && n < 3) begin
      step();
      n++;
      if (wb.wbs_ack_o === 1'b1) begin
        lat = n;
        rd  = wb.wbs_dat_o;
      end
    end
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    step();
  endtask

  task automatic reg_wr(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd;
    int          lat;
    wb_xfer(1'b1, BASE + 32'(off), dat, sel, rd, lat);
    check($sformatf("wr_ack_%02h", off), 32'(lat), 32'd1);
  endtask

  task automatic reg_rd(input logic [7:0] off, output logic [31:0] rd);
    int lat;
    wb_xfer(1'b0, BASE + 32'(off), 32'h0, 4'hF, rd, lat);
    check($sformatf("rd_ack_%02h", off), 32'(lat), 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  off;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, e_out, e_oeb;
    logic [7:0]  offs[10];
    int          lat, acks, prev_ack, dbl;

    rst = 1'b1; pad_in = '0; core_out = '0; core_oeb = '1;
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    wb.wbs_sel_i = 0; wb.wbs_adr_i = 0; wb.wbs_dat_i = 0;
    model_reset();
    @(negedge clk);
    repeat (3) step();
    check("rst_ack", 32'(wb.wbs_ack_o), 32'd0);
    check("rst_dat", wb.wbs_dat_o, 32'h0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    step();

    // ---------------- table-driven register vectors ----------------
    vecs.push_back('{1'b0, OFF_MODE,     4'hF, 32'h0,         32'h0000_0000});
    vecs.push_back('{1'b0, OFF_OUT,      4'hF, 32'h0,         32'h0000_0000});
    vecs.push_back('{1'b0, OFF_OEB,      4'hF, 32'h0,         32'h0000_FFFF});
    vecs.push_back('{1'b0, OFF_IN,       4'hF, 32'h0,         32'h0000_0000});
    vecs.push_back('{1'b0, OFF_RISE_EN,  4'hF, 32'h0,         32'h0000_0000});
    vecs.push_back('{1'b0, OFF_FALL_EN,  4'hF, 32'h0,         32'h0000_0000});
    vecs.push_back('{1'b0, OFF_IRQ_STAT, 4'hF, 32'h0,         32'h0000_0000});
    vecs.push_back('{1'b0, OFF_ID,       4'hF, 32'h0,         32'h10C0_0010});
    vecs.push_back('{1'b0, 8'h40,        4'hF, 32'h0,         32'h0000_0000});
    vecs.push_back('{1'b1, OFF_OUT,      4'h1, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b0, OFF_OUT,      4'hF, 32'h0,         32'h0000_00FF});
    vecs.push_back('{1'b1, OFF_OUT,      4'hF, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b0, OFF_OUT,      4'hF, 32'h0,         32'h0000_FFFF});
    vecs.push_back('{1'b1, OFF_OUT,      4'h6, 32'h0000_0000, 32'h0});
    vecs.push_back('{1'b0, OFF_OUT,      4'hF, 32'h0,         32'h0000_00FF});
    vecs.push_back('{1'b1, OFF_OUT,      4'hF, 32'h0000_0000, 32'h0});
    vecs.push_back('{1'b1, OFF_ID,       4'hF, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b0, OFF_ID,       4'hF, 32'h0,         32'h10C0_0010});
    vecs.push_back('{1'b1, OFF_IN,       4'hF, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b0, OFF_IN,       4'hF, 32'h0,         32'h0000_0000});
    vecs.push_back('{1'b1, 8'h40,        4'hF, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b0, OFF_MODE,     4'hF, 32'h0,         32'h0000_0000});

    foreach (vecs[i]) begin
      wb_xfer(vecs[i].we, BASE + 32'(vecs[i].off), vecs[i].dat, vecs[i].sel, rd, lat);
      check($sformatf("vec%0d_ack", i), 32'(lat), 32'd1);
      if (!vecs[i].we) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
    end

    // ---------------- pad mux ----------------
    core_out = '0; core_oeb = '1;
    reg_wr(OFF_MODE, 32'h0001, 4'hF);
    reg_wr(OFF_OUT,  32'h0001, 4'hF);
    reg_wr(OFF_OEB,  32'hFFFE, 4'hF);
    step();
    check("mux_out0", 32'(pad_out[0]), 32'd1);
    check("mux_oeb0", 32'(pad_oeb[0]), 32'd0);
    check("mux_out1_core", 32'(pad_out[1]), 32'd0);
    check("mux_oeb1_core", 32'(pad_oeb[1]), 32'd1);
    core_out = 16'h0002; core_oeb = 16'hFFFD;
    step();
    check("mux_out1_follow", 32'(pad_out[1]), 32'd1);
    check("mux_oeb1_follow", 32'(pad_oeb[1]), 32'd0);
    check("mux_out0_reg", 32'(pad_out[0]), 32'd1);

    // ---------------- rise edge interrupt timing ----------------
    reg_wr(OFF_RISE_EN, 32'h4, 4'hF);
    pad_in[2] = 1'b1;
    step();
    check("rise_irq_c1", 32'(irq), 32'd0);
    step();
    check("rise_irq_c2", 32'(irq), 32'd0);
    // This read is acked on the third edge: IN already shows the pad.
    wb_xfer(1'b0, BASE + 32'(OFF_IN), 32'h0, 4'hF, rd, lat);
    check("rise_in", rd, 32'h4);
    check("rise_irq_c3", 32'(irq), 32'd1);
    reg_rd(OFF_IRQ_STAT, rd);
    check("rise_stat", rd, 32'h4);
    pad_in[2] = 1'b0;
    repeat (4) step();
    reg_rd(OFF_IRQ_STAT, rd);
    check("fall_disabled_stat", rd, 32'h4);

    // ---------------- W1C colliding with a new set ----------------
    pad_in[2] = 1'b1;
    step();
    step();
    reg_wr(OFF_IRQ_STAT, 32'h4, 4'hF);   // acked on the same edge as the rise
    reg_rd(OFF_IRQ_STAT, rd);
    check("w1c_set_wins", rd, 32'h4);
    check("w1c_set_irq", 32'(irq), 32'd1);
    reg_wr(OFF_IRQ_STAT, 32'h4, 4'hF);
    reg_rd(OFF_IRQ_STAT, rd);
    check("w1c_clear", rd, 32'h0);
    check("w1c_irq_drop", 32'(irq), 32'd0);

    // ---------------- out-of-window access ----------------
    wb_xfer(1'b0, BASE + 32'h100, 32'h0, 4'hF, rd, lat);
    check("outside_no_ack", 32'(lat), 32'd0);

    // ---------------- back-to-back strobes ----------------
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
    wb.wbs_adr_i = BASE + 32'(OFF_ID); wb.wbs_sel_i = 4'hF;
    acks = 0; prev_ack = 0; dbl = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (wb.wbs_ack_o === 1'b1) begin
        acks++;
        if (prev_ack != 0) dbl++;
        if (wb.wbs_dat_o !== 32'h10C0_0010) dbl++;
      end
      prev_ack = (wb.wbs_ack_o === 1'b1) ? 1 : 0;
    end
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
    step();
    check("b2b_ack_count", 32'(acks), 32'd4);
    check("b2b_no_consecutive", 32'(dbl), 32'd0);

    // ---------------- reset during ACK of a write ----------------
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b1;
    wb.wbs_adr_i = BASE + 32'(OFF_OUT); wb.wbs_dat_i = 32'h1234; wb.wbs_sel_i = 4'hF;
    step();
    check("rstmid_ack_hi", 32'(wb.wbs_ack_o), 32'd1);
    rst = 1'b1;
    step();
    check("rstmid_ack_lo", 32'(wb.wbs_ack_o), 32'd0);
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    rst = 1'b0;
    step();
    reg_rd(OFF_OUT, rd);
    check("rstmid_out", rd, 32'h0);

    // ---------------- randomized against the model ----------------
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h40, 8'h80};
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          pad_in = pad_in ^ N'($urandom);
          repeat ($urandom_range(1, 4)) step();
        end
        1: begin
          wb_xfer(1'b1, BASE + 32'(offs[$urandom_range(0, 9)]), $urandom,
                  4'($urandom), rd, lat);
          check("rnd_wr_ack", 32'(lat), 32'd1);
        end
        2: begin
          wb_xfer(1'b0, BASE + 32'(offs[$urandom_range(0, 9)]), 32'h0, 4'hF, rd, lat);
          check("rnd_rd_ack", 32'(lat), 32'd1);
          check("rnd_rd", rd, m_exp_rd);
        end
        default: begin
          core_out = N'($urandom);
          core_oeb = N'($urandom);
          step();
        end
      endcase
      for (int b = 0; b < N; b++) begin
        e_out[b] = m_mode[b] ? m_out[b] : core_out[b];
        e_oeb[b] = m_mode[b] ? m_oeb[b] : core_oeb[b];
      end
      check("rnd_pad_out", 32'(pad_out), e_out & PMASK);
      check("rnd_pad_oeb", 32'(pad_oeb), e_oeb & PMASK);
      check("rnd_irq", 32'(irq), (m_stat != 0) ? 32'd1 : 32'd0);
      check("rnd_core_in", 32'(core_in), 32'(pad_in));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_pad_ctrl.md
# io_pad_ctrl

Wishbone-programmable pad controller for the user project area; the successor to fixed pad-slice routing. It owns N_PADS GPIO pads. Per pad, it chooses between core-driven passthrough and register-driven output/enable. It synchronises pad inputs and latches rising/falling-edge interrupts. It sits between the user project wrapper pads and the design core, on the management Wishbone bus.

## Interface
Parameters:
- N_PADS, 16: number of controlled pads, 1..32.
- BASE_ADR, 32'h3000_0000: register window base; 256-byte window.
- SYNC_STAGES, 2: input synchroniser depth, 2..3.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic slave controls.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- pad_in  in  N_PADS  from pads (io_in slice).
- pad_out  out  N_PADS  to pads (io_out slice).
- pad_oeb  out  N_PADS  to pads; 1 = output disabled.
- core_out, core_oeb  in  N_PADS each  core-requested drive.
- core_in  out  N_PADS  pad_in passed to core unregistered.
- irq  out  1  OR of all IRQ_STAT bits.

## Operation
- Registers, as word offsets within the window:
  - 0x00 MODE: 1 = register-driven.
  - 0x04 OUT.
  - 0x08 OEB.
  - 0x0C IN: read-only, synchronised pad_in.
  - 0x10 RISE_EN.
  - 0x14 FALL_EN.
  - 0x18 IRQ_STAT: write-1-to-clear.
  - 0x1C ID: read-only, {16'h10C0, 8'd0, 8'(N_PADS)}.
- Pad mux, combinational per pad i:
  - pad_out[i] = MODE[i] ? OUT[i] : core_out[i].
  - pad_oeb[i] = MODE[i] ? OEB[i] : core_oeb[i].
- A cycle is selected when cyc&stb and wbs_adr_i[31:8]==BASE_ADR[31:8]. Unselected cycles are ignored, with no ack.
- Selected in-window access to an unmapped offset: ack asserted, read returns 0, write has no effect.
- Writes honour wbs_sel_i per byte.
- Register bits at or above N_PADS read 0 and ignore writes.
- Writes to IN and ID are ignored.
- Edge detect on the last synchroniser stage s versus its previous value p:
  - rise = s & ~p; fall = ~s & p.
  - IRQ_STAT[i] sets on (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]).
  - An edge is not recorded while the corresponding enable is 0.
- Same-cycle W1C and new set on the same bit: set wins.

## Timing
- Reset values:
  - MODE=0, OUT=0, OEB=all ones (within N_PADS), RISE_EN=0, FALL_EN=0, IRQ_STAT=0.
  - Synchroniser and previous-value flops = 0.
  - wbs_ack_o=0, wbs_dat_o=0, irq=0.
- Wishbone handshake:
  - wbs_ack_o rises the cycle after a selected cyc&stb, as a one-cycle pulse.
  - The write takes effect on that same edge.
  - wbs_dat_o is valid while ack=1 and 0 otherwise.
  - Back-to-back strobes: ack is low for at least one cycle between transfers; the ack register blocks re-acking while ack=1.
- pad_in to IN: SYNC_STAGES cycles.
- pad_in to IRQ_STAT set: SYNC_STAGES+1 cycles. irq is combinational from IRQ_STAT.
- Pad outputs follow a MODE/OUT/OEB write in the cycle after ack.
- Reset asserted mid-transfer: ack is forced low next cycle; the pending write is discarded.
- A pad held high through reset release produces a rise event SYNC_STAGES+1 cycles later. It is recorded only if RISE_EN is set by then.

## Structure
- Package io_pad_ctrl_pkg holds:
  - register offset localparams;
  - ID_MAGIC (16'h10C0);
  - the reset value constants.
- Sub-module io_edge_sync (one pad: synchroniser chain, previous flop, rise/fall outputs) is instantiated in a generate loop of N_PADS.
- The top level holds the Wishbone FSM (IDLE/ACK), the register file, W1C logic and the pad mux.

## Test plan
- Reset, then read every offset: MODE=0, OEB=0x0000FFFF (N_PADS=16), ID=0x10C00010, unmapped 0x40 reads 0; every access acks in one cycle.
- Write MODE=0x0001, OUT=0x0001, OEB=0xFFFE with core_out=0 -> pad_out[0]=1 and pad_oeb[0]=0 one cycle after ack; pad 1 still follows core_out/core_oeb.
- Write OUT=0xFFFFFFFF with sel=4'b0001 -> OUT reads 0x000000FF; with N_PADS=8, write 0xFFFF reads 0x00FF.
- RISE_EN=0x4, toggle pad_in[2] 0->1 -> IN[2]=1 after 2 cycles, IRQ_STAT=0x4 and irq=1 after 3; a fall with FALL_EN=0 leaves IRQ_STAT unchanged.
- W1C 0x4 on the same cycle as a new rise on pad 2 -> IRQ_STAT stays 0x4; a later W1C clears it and irq drops.
- Assert wb_rst_i during the ACK state of a write to OUT -> ack low next cycle, OUT remains 0; back-to-back strobes show ack high at most every other cycle.
